// File: rtl/bscan_jtag_master.sv
// Host-side JTAG master: resets the TAP, loads the USER IR once, then runs one DR scan per request.
// Define BSCAN_JTAG_MASTER_STATS_EN to add the scan_count output.
module bscan_jtag_master #(
   parameter int                WIDTH   = 32,
   parameter int                IR_LEN  = 6,
   parameter logic [IR_LEN-1:0] USER_IR = 6'h23,
   parameter int                TCK_DIV = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             req_enq__ENA,
   input  logic [WIDTH-1:0] req_enq_v,
   output logic             req_enq__RDY,
   output logic             rsp_enq__ENA,
   output logic [WIDTH-1:0] rsp_enq_v,
   input  logic             rsp_enq__RDY,
   output logic             TCK,
   output logic             TMS,
   output logic             TDI,
   input  logic             TDO,
   output logic             busy
`ifdef BSCAN_JTAG_MASTER_STATS_EN
  ,output logic [7:0]       scan_count
`endif
);

   localparam int MAXL = (WIDTH > IR_LEN) ? WIDTH : IR_LEN;
   localparam int CW   = $clog2(MAXL + 6);
   localparam int DW   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

   localparam logic [CW-1:0] RST_EDGES = CW'(6);
   localparam logic [CW-1:0] IR_EDGES  = CW'(IR_LEN + 6);
   localparam logic [CW-1:0] DR_EDGES  = CW'(WIDTH + 5);
   localparam logic [CW-1:0] SH_FIRST  = CW'(3);
   localparam logic [CW-1:0] SH_END    = CW'(WIDTH + 3);
   localparam logic [DW-1:0] DIV_LAST  = DW'(TCK_DIV - 1);

   typedef enum logic [2:0] {
      S_TAP_RST,
      S_IR_LOAD,
      S_IDLE,
      S_DR_SCAN,
      S_RSP
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nx;
   logic [CW-1:0]    w_total;
   logic [DW-1:0]    r_div;
   logic             r_tck;
   logic             r_tms;
   logic             r_tdi;
   logic [WIDTH-1:0] r_req;
   logic [WIDTH-1:0] w_req_nx;
   logic [WIDTH-1:0] r_rsp;
   logic [1:0]       w_pins;
   logic             w_run;
   logic             w_tick;
   logic             w_rise;
   logic             w_fall;
   logic             w_req_acc;
   logic             w_rsp_acc;

   // TMS/TDI for edge k of the given state; returns {tms, tdi}
   function automatic logic [1:0] f_pins(
      input state_t           st,
      input logic [CW-1:0]    k,
      input logic [WIDTH-1:0] d
   );
      int               i;
      logic [IR_LEN-1:0] ir_s;
      logic [WIDTH-1:0]  dr_s;
      i      = int'(k);
      ir_s   = '0;
      dr_s   = '0;
      f_pins = 2'b00;
      case (st)
         S_TAP_RST: f_pins[1] = (i < 5);
         S_IR_LOAD: begin
            if (i < 2) begin
               f_pins[1] = 1'b1;
            end else if (i >= 4 && i < IR_LEN + 4) begin
               ir_s   = USER_IR >> (i - 4);
               f_pins = {i == IR_LEN + 3, ir_s[0]};
            end else if (i == IR_LEN + 4) begin
               f_pins[1] = 1'b1;
            end
         end
         S_DR_SCAN: begin
            if (i == 0) begin
               f_pins[1] = 1'b1;
            end else if (i >= 3 && i < WIDTH + 3) begin
               dr_s   = d >> (i - 3);
               f_pins = {i == WIDTH + 2, dr_s[0]};
            end else if (i == WIDTH + 3) begin
               f_pins[1] = 1'b1;
            end
         end
         default: f_pins = 2'b00;
      endcase
   endfunction

   always_comb begin
      w_total = '0;
      case (r_state)
         S_TAP_RST: w_total = RST_EDGES;
         S_IR_LOAD: w_total = IR_EDGES;
         S_DR_SCAN: w_total = DR_EDGES;
         default:   w_total = '0;
      endcase
   end

   assign w_run = (r_state == S_TAP_RST || r_state == S_IR_LOAD ||
                   r_state == S_DR_SCAN) && (r_cnt != w_total);
   assign w_tick    = w_run && (r_div == DIV_LAST);
   assign w_rise    = w_tick && !r_tck;
   assign w_fall    = w_tick && r_tck;
   assign w_req_acc = req_enq__ENA && (r_state == S_IDLE);
   assign w_rsp_acc = rsp_enq__RDY && (r_state == S_RSP);
   assign w_req_nx  = w_req_acc ? req_enq_v : r_req;

   // One idle CLK after the final falling TCK before changing state
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = w_fall ? r_cnt + 1'b1 : r_cnt;
      case (r_state)
         S_TAP_RST: if (!w_run) begin
            w_state_nx = S_IR_LOAD;
            w_cnt_nx   = '0;
         end
         S_IR_LOAD: if (!w_run) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end
         S_IDLE: if (w_req_acc) begin
            w_state_nx = S_DR_SCAN;
            w_cnt_nx   = '0;
         end
         S_DR_SCAN: if (!w_run) begin
            w_state_nx = S_RSP;
            w_cnt_nx   = '0;
         end
         S_RSP: if (w_rsp_acc) begin
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_TAP_RST;
      endcase
   end

   assign w_pins = f_pins(w_state_nx, w_cnt_nx, w_req_nx);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_TAP_RST;
         r_cnt   <= '0;
         r_div   <= '0;
         r_tck   <= 1'b0;
         r_tms   <= 1'b1;
         r_tdi   <= 1'b0;
         r_req   <= '0;
         r_rsp   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_tms   <= w_pins[1];
         r_tdi   <= w_pins[0];
         r_req   <= w_req_nx;
         r_div   <= (!w_run || w_tick) ? '0 : r_div + 1'b1;
         if (w_tick) r_tck <= ~r_tck;
         if (w_rise && r_state == S_DR_SCAN &&
             r_cnt >= SH_FIRST && r_cnt < SH_END)
            r_rsp <= {TDO, r_rsp[WIDTH-1:1]};
      end
   end

`ifdef BSCAN_JTAG_MASTER_STATS_EN
   logic [7:0] r_scan_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_scan_cnt <= '0;
      else if (w_rsp_acc) r_scan_cnt <= r_scan_cnt + 1'b1;
   end

   assign scan_count = r_scan_cnt;
`endif

   assign TCK          = r_tck;
   assign TMS          = r_tms;
   assign TDI          = r_tdi;
   assign req_enq__RDY = (r_state == S_IDLE);
   assign rsp_enq__ENA = (r_state == S_RSP);
   assign rsp_enq_v    = (r_state == S_RSP) ? r_rsp : '0;
   assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_bscan_jtag_master.sv
// Directed bench for bscan_jtag_master with a behavioural TAP + Bscan user register.
// Build with BSCAN_JTAG_MASTER_STATS_EN to also exercise scan_count.
module tb_bscan_jtag_master;
   localparam int W = 32;

   typedef enum logic [3:0] {
      TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDR,
      SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPIR
   } tap_t;

   logic         clk = 0;
   logic         nrst = 0;
   logic         req_ena = 0;
   logic [W-1:0] req_v = '0;
   logic         rsp_rdy = 0;
   logic         tdo = 0;
   logic         req_rdy, rsp_ena, tck, tms, tdi, busy;
   logic [W-1:0] rsp_v;
`ifdef BSCAN_JTAG_MASTER_STATS_EN
   logic [7:0]   scan_count;
`endif

   int n_chk = 0;
   int n_fail = 0;

   bscan_jtag_master dut (
      .CLK(clk), .nRST(nrst),
      .req_enq__ENA(req_ena), .req_enq_v(req_v), .req_enq__RDY(req_rdy),
      .rsp_enq__ENA(rsp_ena), .rsp_enq_v(rsp_v), .rsp_enq__RDY(rsp_rdy),
      .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo), .busy(busy)
`ifdef BSCAN_JTAG_MASTER_STATS_EN
     ,.scan_count(scan_count)
`endif
   );

   always #5 clk = ~clk;

   // Target model: TAP controller plus a 32-bit user DR at IR 6'h23
   tap_t         tap = SHDR;
   logic [5:0]   ir = '0;
   logic [5:0]   ir_sh = '0;
   logic [W-1:0] dr = '0;
   logic [W-1:0] echo = '0;
   logic [W-1:0] upd = '0;
   logic [W-1:0] cap_force = '0;
   logic         force_en = 0;
   int           n_rise = 0;
   int           dr_n = 0;

   function automatic tap_t tap_nx(input tap_t s, input logic m);
      case (s)
         TLR:     return m ? TLR   : RTI;
         RTI:     return m ? SELDR : RTI;
         SELDR:   return m ? SELIR : CAPDR;
         CAPDR:   return m ? EX1DR : SHDR;
         SHDR:    return m ? EX1DR : SHDR;
         EX1DR:   return m ? UPDR  : PAUSEDR;
         PAUSEDR: return m ? EX2DR : PAUSEDR;
         EX2DR:   return m ? UPDR  : SHDR;
         UPDR:    return m ? SELDR : RTI;
         SELIR:   return m ? TLR   : CAPIR;
         CAPIR:   return m ? EX1IR : SHIR;
         SHIR:    return m ? EX1IR : SHIR;
         EX1IR:   return m ? UPIR  : PAUSEIR;
         PAUSEIR: return m ? EX2IR : PAUSEIR;
         EX2IR:   return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      n_rise <= n_rise + 1;
      case (tap)
         TLR:   ir <= 6'h01;
         CAPIR: ir_sh <= 6'b000001;
         SHIR:  ir_sh <= {tdi, ir_sh[5:1]};
         UPIR:  ir <= ir_sh;
         CAPDR: begin
            if (ir == 6'h23) dr <= force_en ? cap_force : echo;
            dr_n <= 0;
         end
         SHDR: begin
            dr   <= {tdi, dr[W-1:1]};
            dr_n <= dr_n + 1;
         end
         UPDR: if (ir == 6'h23) begin
            upd  <= dr;
            echo <= dr;
         end
         default: ;
      endcase
      tap <= tap_nx(tap, tms);
   end

   always @(negedge tck)
      tdo <= (tap == SHDR) ? dr[0] : (tap == SHIR) ? ir_sh[0] : 1'b0;

   // Called at a negedge; returns at the negedge where the response is first seen
   task automatic do_req(input logic [W-1:0] v, output logic [W-1:0] got,
                         output int wt, output int lat);
      wt = 0;
      while (!req_rdy && wt < 400) begin
         @(negedge clk);
         wt++;
      end
      req_v   = v;
      req_ena = 1;
      @(posedge clk);
      @(negedge clk);
      req_ena = 0;
      lat = 0;
      while (!rsp_ena && lat < 300) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      got = rsp_v;
   endtask

   task automatic test_reset();
      int   base, t;
      tap_t tap6;
      bit   seen6, rsp_seen;
      nrst = 0;
      repeat (3) @(negedge clk);
      n_chk++; if (tck !== 1'b0) begin n_fail++; $display("FAIL rst_tck got %b want 0", tck); end
      n_chk++; if (tms !== 1'b1) begin n_fail++; $display("FAIL rst_tms got %b want 1", tms); end
      n_chk++; if (tdi !== 1'b0) begin n_fail++; $display("FAIL rst_tdi got %b want 0", tdi); end
      n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got %b want 0", req_rdy); end
      n_chk++; if (rsp_ena !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_ena got %b want 0", rsp_ena); end
      n_chk++; if (rsp_v !== '0) begin n_fail++; $display("FAIL rst_rsp_v got %h want 0", rsp_v); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b want 1", busy); end
      base = n_rise;
      nrst = 1;
      t = 0; seen6 = 0; rsp_seen = 0; tap6 = TLR;
      while (!req_rdy && t < 300) begin
         @(negedge clk);
         t++;
         if (rsp_ena) rsp_seen = 1;
         if (!seen6 && n_rise - base == 6) begin seen6 = 1; tap6 = tap; end
      end
      n_chk++; if (t >= 300) begin n_fail++; $display("FAIL init_timeout got %0d cycles want <300", t); end
      n_chk++; if (tap6 !== RTI) begin n_fail++; $display("FAIL tap_after_6 got %0d want %0d", tap6, RTI); end
      n_chk++; if (n_rise - base !== 18) begin n_fail++; $display("FAIL init_edges got %0d want 18", n_rise - base); end
      n_chk++; if (ir !== 6'h23) begin n_fail++; $display("FAIL init_ir got %h want 23", ir); end
      n_chk++; if (tap !== RTI) begin n_fail++; $display("FAIL init_tap got %0d want %0d", tap, RTI); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy got %b want 0", busy); end
      n_chk++; if (rsp_seen) begin n_fail++; $display("FAIL init_rsp got 1 want 0"); end
   endtask

   task automatic test_scan();
      logic [W-1:0] got;
      int wt, lat, base;
      force_en  = 1;
      cap_force = 32'hA5A5_0001;
      rsp_rdy   = 1;
      base      = n_rise;
      do_req(32'hDEAD_BEEF, got, wt, lat);
      n_chk++; if (lat !== 149) begin n_fail++; $display("FAIL scan_latency got %0d want 149", lat); end
      n_chk++; if (got !== 32'hA5A5_0001) begin n_fail++; $display("FAIL scan_rsp got %h want a5a50001", got); end
      n_chk++; if (n_rise - base !== 37) begin n_fail++; $display("FAIL scan_edges got %0d want 37", n_rise - base); end
      n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL scan_rdy_in_rsp got %b want 0", req_rdy); end
      @(negedge clk);
      n_chk++; if (rsp_ena !== 1'b0) begin n_fail++; $display("FAIL scan_rsp_drop got %b want 0", rsp_ena); end
      n_chk++; if (rsp_v !== '0) begin n_fail++; $display("FAIL scan_rsp_v_zero got %h want 0", rsp_v); end
      n_chk++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL scan_rdy_back got %b want 1", req_rdy); end
      n_chk++; if (upd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL scan_update got %h want deadbeef", upd); end
      n_chk++; if (tap !== RTI) begin n_fail++; $display("FAIL scan_tap_end got %0d want %0d", tap, RTI); end
      force_en = 0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] g1, g2;
      int wt1, lat1, wt2, lat2;
      rsp_rdy = 1;
      do_req(32'h1, g1, wt1, lat1);
      n_chk++; if (g1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_rsp1 got %h want deadbeef", g1); end
      n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_same got %b want 0", req_rdy); end
      do_req(32'h2, g2, wt2, lat2);
      n_chk++; if (wt2 !== 1) begin n_fail++; $display("FAIL b2b_gap got %0d want 1", wt2); end
      n_chk++; if (g2 !== 32'h1) begin n_fail++; $display("FAIL b2b_rsp2 got %h want 00000001", g2); end
      n_chk++; if (lat2 !== 149) begin n_fail++; $display("FAIL b2b_latency got %0d want 149", lat2); end
      @(negedge clk);
      n_chk++; if (upd !== 32'h2) begin n_fail++; $display("FAIL b2b_update got %h want 00000002", upd); end
   endtask

   task automatic test_stall();
      logic [W-1:0] got;
      int wt, lat;
      rsp_rdy = 0;
      do_req(32'h0000_00F0, got, wt, lat);
      n_chk++; if (got !== 32'h2) begin n_fail++; $display("FAIL stall_rsp got %h want 00000002", got); end
      req_v   = 32'hFFFF_FFFF;
      req_ena = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_chk++; if (rsp_ena !== 1'b1) begin n_fail++; $display("FAIL stall_ena[%0d] got %b want 1", i, rsp_ena); end
         n_chk++; if (rsp_v !== 32'h2) begin n_fail++; $display("FAIL stall_v[%0d] got %h want 00000002", i, rsp_v); end
         n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy[%0d] got %b want 0", i, req_rdy); end
         n_chk++; if (tck !== 1'b0) begin n_fail++; $display("FAIL stall_tck[%0d] got %b want 0", i, tck); end
      end
      req_ena = 0;
      rsp_rdy = 1;
      n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_accept got %b want 0", req_rdy); end
      @(negedge clk);
      n_chk++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL stall_rdy_next got %b want 1", req_rdy); end
      n_chk++; if (rsp_ena !== 1'b0) begin n_fail++; $display("FAIL stall_ena_off got %b want 0", rsp_ena); end
      n_chk++; if (rsp_v !== '0) begin n_fail++; $display("FAIL stall_v_off got %h want 0", rsp_v); end
      repeat (10) @(negedge clk);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_ignored_req got busy %b want 0", busy); end
      n_chk++; if (upd !== 32'hF0) begin n_fail++; $display("FAIL stall_update got %h want 000000f0", upd); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] got;
      int t, base, wt, lat;
      bit rsp_seen;
      rsp_rdy = 1;
      req_v   = 32'h0;
      req_ena = 1;
      @(posedge clk);
      @(negedge clk);
      req_ena = 0;
      t = 0;
      while (!(tap == SHDR && dr_n == 17) && t < 300) begin
         @(negedge clk);
         t++;
      end
      n_chk++; if (t >= 300) begin n_fail++; $display("FAIL mid_reach_bit17 got %0d cycles want <300", t); end
      nrst = 0;
      #1;
      n_chk++; if (tck !== 1'b0) begin n_fail++; $display("FAIL mid_tck got %b want 0", tck); end
      n_chk++; if (tms !== 1'b1) begin n_fail++; $display("FAIL mid_tms got %b want 1", tms); end
      n_chk++; if (tdi !== 1'b0) begin n_fail++; $display("FAIL mid_tdi got %b want 0", tdi); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy); end
      n_chk++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_req_rdy got %b want 0", req_rdy); end
      n_chk++; if (rsp_ena !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_ena got %b want 0", rsp_ena); end
      repeat (2) @(negedge clk);
      base = n_rise;
      nrst = 1;
      t = 0; rsp_seen = 0;
      while (!req_rdy && t < 300) begin
         @(negedge clk);
         t++;
         if (rsp_ena) rsp_seen = 1;
      end
      n_chk++; if (rsp_seen) begin n_fail++; $display("FAIL mid_no_rsp got 1 want 0"); end
      n_chk++; if (n_rise - base !== 18) begin n_fail++; $display("FAIL mid_replay_edges got %0d want 18", n_rise - base); end
      n_chk++; if (ir !== 6'h23) begin n_fail++; $display("FAIL mid_ir got %h want 23", ir); end
      n_chk++; if (tap !== RTI) begin n_fail++; $display("FAIL mid_tap got %0d want %0d", tap, RTI); end
      force_en  = 1;
      cap_force = 32'h1234_5678;
      do_req(32'h5, got, wt, lat);
      n_chk++; if (got !== 32'h1234_5678) begin n_fail++; $display("FAIL post_rst_rsp got %h want 12345678", got); end
      n_chk++; if (lat !== 149) begin n_fail++; $display("FAIL post_rst_latency got %0d want 149", lat); end
      @(negedge clk);
      force_en = 0;
   endtask

`ifdef BSCAN_JTAG_MASTER_STATS_EN
   task automatic test_stats();
      logic [W-1:0] got;
      int wt, lat;
      rsp_rdy = 1;
      n_chk++; if (scan_count !== 8'd1) begin n_fail++; $display("FAIL stats_one got %0d want 1", scan_count); end
      for (int i = 0; i < 255; i++) begin
         do_req(i, got, wt, lat);
         @(negedge clk);
      end
      n_chk++; if (scan_count !== 8'd0) begin n_fail++; $display("FAIL stats_wrap got %0d want 0", scan_count); end
      do_req(32'h7, got, wt, lat);
      @(negedge clk);
      n_chk++; if (scan_count !== 8'd1) begin n_fail++; $display("FAIL stats_257 got %0d want 1", scan_count); end
   endtask
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_scan();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef BSCAN_JTAG_MASTER_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
